// File: rtl/adder_arbiter.sv
// adder_arbiter
// Round-robin arbiter/sequencer that time-shares one external combinational
// adder between N requesters. One operation takes IDLE -> EXECUTE -> RESULT:
// the winner's operands are registered towards the adder, the sum is
// registered one cycle later and held with the winner's tag until acked.
//
// Ports:
//   i_CLOCK_POS      rising-edge clock
//   i_RESET_POS      synchronous active-high reset
//   i_REQUEST        per-requester request level (bit k = requester k)
//   i_OPERAND_ONE    requester k operand one at [k*SIZE +: SIZE]
//   i_OPERAND_TWO    requester k operand two, same packing
//   o_GRANT          one-hot grant, high during the EXECUTE cycle
//   o_VECTOR_ONE     registered operand one to the shared adder
//   o_VECTOR_TWO     registered operand two to the shared adder
//   i_VECTOR_SUM     SIZE+1 bit sum returned by the shared adder
//   o_RESULT         registered sum (carry in the MSB)
//   o_RESULT_TAG     index of the requester owning o_RESULT
//   o_RESULT_VALID   result available, held until acknowledged
//   i_RESULT_ACK     consumer accepts the result
//   o_BUSY           high whenever the sequencer is not idle
module adder_arbiter #(
    parameter int SIZE = 6,
    parameter int N    = 4,
    parameter int TAG  = 2
) (
    input  logic                i_CLOCK_POS,
    input  logic                i_RESET_POS,
    input  logic [N-1:0]        i_REQUEST,
    input  logic [N*SIZE-1:0]   i_OPERAND_ONE,
    input  logic [N*SIZE-1:0]   i_OPERAND_TWO,
    output logic [N-1:0]        o_GRANT,
    output logic [SIZE-1:0]     o_VECTOR_ONE,
    output logic [SIZE-1:0]     o_VECTOR_TWO,
    input  logic [SIZE:0]       i_VECTOR_SUM,
    output logic [SIZE:0]       o_RESULT,
    output logic [TAG-1:0]      o_RESULT_TAG,
    output logic                o_RESULT_VALID,
    input  logic                i_RESULT_ACK,
    output logic                o_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_RESULT  = 2'd2
    } state_t;

    state_t          state_r, state_next_s;
    logic [TAG-1:0]  ptr_r, ptr_next_s;
    logic [TAG-1:0]  winner_r, winner_next_s;
    logic [N-1:0]    grant_r, grant_next_s;
    logic [SIZE-1:0] vec_one_r, vec_one_next_s;
    logic [SIZE-1:0] vec_two_r, vec_two_next_s;
    logic [SIZE:0]   result_r, result_next_s;
    logic [TAG-1:0]  result_tag_r, result_tag_next_s;
    logic            valid_r, valid_next_s;
    logic            busy_r, busy_next_s;

    logic            found_s;
    logic            hit_s;
    logic [TAG-1:0]  search_idx_s;
    logic [TAG:0]    cand_s;
    logic [TAG:0]    wrapped_s;

    function automatic logic [N-1:0] to_one_hot(input logic [TAG-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Round-robin search: first requester at or after the pointer, wrapping mod N.
    // ptr < N and i < N, so a single conditional subtract performs the wrap.
    always_comb begin
        found_s      = 1'b0;
        hit_s        = 1'b0;
        search_idx_s = '0;
        cand_s       = '0;
        wrapped_s    = '0;
        for (int i = 0; i < N; i++) begin
            cand_s       = {1'b0, ptr_r} + (TAG+1)'(i);
            wrapped_s    = (cand_s >= (TAG+1)'(N)) ? (cand_s - (TAG+1)'(N)) : cand_s;
            hit_s        = i_REQUEST[wrapped_s[TAG-1:0]] & ~found_s;
            search_idx_s = hit_s ? wrapped_s[TAG-1:0] : search_idx_s;
            found_s      = found_s | hit_s;
        end
    end

    // Next-state and next-output logic of the IDLE/EXECUTE/RESULT sequencer.
    always_comb begin
        state_next_s      = state_r;
        ptr_next_s        = ptr_r;
        winner_next_s     = winner_r;
        grant_next_s      = grant_r;
        vec_one_next_s    = vec_one_r;
        vec_two_next_s    = vec_two_r;
        result_next_s     = result_r;
        result_tag_next_s = result_tag_r;
        valid_next_s      = valid_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_next_s   = ST_EXECUTE;
                    grant_next_s   = to_one_hot(search_idx_s);
                    winner_next_s  = search_idx_s;
                    vec_one_next_s = i_OPERAND_ONE[search_idx_s*SIZE +: SIZE];
                    vec_two_next_s = i_OPERAND_TWO[search_idx_s*SIZE +: SIZE];
                end else begin
                    grant_next_s   = '0;
                end
            end
            ST_EXECUTE: begin
                // Adder inputs have been stable for a full cycle; capture its sum.
                result_next_s     = i_VECTOR_SUM;
                result_tag_next_s = winner_r;
                valid_next_s      = 1'b1;
                grant_next_s      = '0;
                state_next_s      = ST_RESULT;
            end
            ST_RESULT: begin
                if (i_RESULT_ACK) begin
                    valid_next_s = 1'b0;
                    ptr_next_s   = (winner_r == TAG'(N-1)) ? '0 : (winner_r + 1'b1);
                    state_next_s = ST_IDLE;
                end else begin
                    valid_next_s = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                grant_next_s = '0;
                valid_next_s = 1'b0;
            end
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            winner_r     <= '0;
            grant_r      <= '0;
            vec_one_r    <= '0;
            vec_two_r    <= '0;
            result_r     <= '0;
            result_tag_r <= '0;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            ptr_r        <= ptr_next_s;
            winner_r     <= winner_next_s;
            grant_r      <= grant_next_s;
            vec_one_r    <= vec_one_next_s;
            vec_two_r    <= vec_two_next_s;
            result_r     <= result_next_s;
            result_tag_r <= result_tag_next_s;
            valid_r      <= valid_next_s;
            busy_r       <= busy_next_s;
        end
    end

    assign o_GRANT        = grant_r;
    assign o_VECTOR_ONE   = vec_one_r;
    assign o_VECTOR_TWO   = vec_two_r;
    assign o_RESULT       = result_r;
    assign o_RESULT_TAG   = result_tag_r;
    assign o_RESULT_VALID = valid_r;
    assign o_BUSY         = busy_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: models the shared adder, drives
// directed and random operations and compares against a transaction-level
// round-robin reference (pointer + scan of the request vector).
module tb_adder_arbiter;

    localparam int SIZE = 6;
    localparam int N    = 4;
    localparam int TAG  = 2;

    logic                clk;
    logic                rst;
    logic [N-1:0]        request;
    logic [N*SIZE-1:0]   operand_one;
    logic [N*SIZE-1:0]   operand_two;
    logic [N-1:0]        grant;
    logic [SIZE-1:0]     vector_one;
    logic [SIZE-1:0]     vector_two;
    logic [SIZE:0]       vector_sum;
    logic [SIZE:0]       result;
    logic [TAG-1:0]      result_tag;
    logic                result_valid;
    logic                result_ack;
    logic                busy;

    logic [SIZE-1:0]     op1_a [N];
    logic [SIZE-1:0]     op2_a [N];

    int n_checks;
    int n_fail;
    int model_ptr;

    adder_arbiter #(.SIZE(SIZE), .N(N), .TAG(TAG)) dut (
        .i_CLOCK_POS    (clk),
        .i_RESET_POS    (rst),
        .i_REQUEST      (request),
        .i_OPERAND_ONE  (operand_one),
        .i_OPERAND_TWO  (operand_two),
        .o_GRANT        (grant),
        .o_VECTOR_ONE   (vector_one),
        .o_VECTOR_TWO   (vector_two),
        .i_VECTOR_SUM   (vector_sum),
        .o_RESULT       (result),
        .o_RESULT_TAG   (result_tag),
        .o_RESULT_VALID (result_valid),
        .i_RESULT_ACK   (result_ack),
        .o_BUSY         (busy)
    );

    // External combinational adder.
    assign vector_sum = {1'b0, vector_one} + {1'b0, vector_two};

    // Pack per-requester operands onto the flat buses.
    always_comb begin
        operand_one = '0;
        operand_two = '0;
        for (int k = 0; k < N; k++) begin
            operand_one[k*SIZE +: SIZE] = op1_a[k];
            operand_two[k*SIZE +: SIZE] = op2_a[k];
        end
    end

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            op1_a[k] = SIZE'($urandom);
            op2_a[k] = SIZE'($urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation starting in IDLE. stall_req is driven while the
    // block is busy (it must be ignored); ack is withheld ack_delay cycles.
    task automatic run_op(input logic [N-1:0] req, input int ack_delay, input logic [N-1:0] stall_req);
        int win;
        int idx;
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        logic [SIZE:0]   exp_sum;
        win = -1;
        for (int k = 0; k < N; k++) begin
            idx = (model_ptr + k) % N;
            if (win < 0 && req[idx]) win = idx;
        end
        request = req;
        if (win < 0) begin
            step();
            check_eq("idle_grant", 32'(grant), 32'd0);
            check_eq("idle_busy", 32'(busy), 32'd0);
            return;
        end
        a       = op1_a[win];
        b       = op2_a[win];
        exp_sum = 7'(a) + 7'(b);
        step();
        check_eq("grant", 32'(grant), 32'(1 << win));
        check_eq("vec_one", 32'(vector_one), 32'(a));
        check_eq("vec_two", 32'(vector_two), 32'(b));
        check_eq("exec_busy", 32'(busy), 32'd1);
        check_eq("exec_valid", 32'(result_valid), 32'd0);
        request    = stall_req;
        result_ack = 1'($urandom);
        rand_ops();
        step();
        check_eq("res_grant", 32'(grant), 32'd0);
        check_eq("result", 32'(result), 32'(exp_sum));
        check_eq("tag", 32'(result_tag), 32'(win));
        check_eq("valid", 32'(result_valid), 32'd1);
        check_eq("res_busy", 32'(busy), 32'd1);
        check_eq("vec_hold", 32'(vector_one), 32'(a));
        for (int d = 0; d < ack_delay; d++) begin
            result_ack = 1'b0;
            step();
            check_eq("stall_valid", 32'(result_valid), 32'd1);
            check_eq("stall_result", 32'(result), 32'(exp_sum));
            check_eq("stall_tag", 32'(result_tag), 32'(win));
            check_eq("stall_grant", 32'(grant), 32'd0);
            check_eq("stall_busy", 32'(busy), 32'd1);
        end
        result_ack = 1'b1;
        step();
        check_eq("ack_valid", 32'(result_valid), 32'd0);
        check_eq("ack_busy", 32'(busy), 32'd0);
        check_eq("ack_grant", 32'(grant), 32'd0);
        check_eq("ack_result", 32'(result), 32'(exp_sum));
        model_ptr  = (win + 1) % N;
        result_ack = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        model_ptr  = 0;
        rst        = 1'b1;
        request    = 4'b1111;
        result_ack = 1'b0;
        rand_ops();

        // Reset held two cycles with every request asserted.
        step();
        step();
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_vec_one", 32'(vector_one), 32'd0);
        check_eq("rst_vec_two", 32'(vector_two), 32'd0);
        check_eq("rst_result", 32'(result), 32'd0);
        check_eq("rst_tag", 32'(result_tag), 32'd0);
        check_eq("rst_valid", 32'(result_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Fairness: all requests held, no ack stall -> 0,1,2,3,0,1.
        for (int i = 0; i < 6; i++) begin
            run_op(4'b1111, 0, 4'b1111);
        end
        check_eq("fair_ptr_model", 32'(model_ptr), 32'd2);

        // Single request from requester 1: 45 + 30.
        op1_a[1] = 6'd45;
        op2_a[1] = 6'd30;
        run_op(4'b0010, 0, 4'b0000);
        check_eq("single_sum", 32'(result), 32'd75);

        // Carry out of the top bit: 63 + 63 on requester 3.
        op1_a[3] = 6'd63;
        op2_a[3] = 6'd63;
        run_op(4'b1000, 1, 4'b0000);
        check_eq("carry_sum", 32'(result), 32'(7'b1111110));
        check_eq("carry_tag", 32'(result_tag), 32'd3);

        // Backpressure: ack withheld 5 cycles while requester 2 requests,
        // then requester 2 is granted on the edge after the ack.
        rand_ops();
        run_op(4'b0100, 5, 4'b0100);
        run_op(4'b0100, 0, 4'b0000);

        // Reset during EXECUTE abandons the operation and clears the pointer.
        request = 4'b0001;
        step();
        check_eq("mid_grant", 32'(grant), 32'd1);
        rst     = 1'b1;
        request = 4'b1111;
        step();
        check_eq("mid_valid", 32'(result_valid), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_grant_clr", 32'(grant), 32'd0);
        check_eq("mid_result", 32'(result), 32'd0);
        rst       = 1'b0;
        request   = 4'b0000;
        model_ptr = 0;
        step();
        check_eq("post_valid", 32'(result_valid), 32'd0);
        check_eq("post_busy", 32'(busy), 32'd0);
        rand_ops();
        run_op(4'b1010, 0, 4'b0000);
        check_eq("post_tag", 32'(result_tag), 32'd1);

        // Randomised operations, including idle cycles and ack stalls.
        for (int i = 0; i < 40; i++) begin
            rand_ops();
            run_op(4'($urandom), int'($urandom_range(0, 3)), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
